// File: rtl/nrisc_interrupt_ctrl_pkg.sv
// Shared defaults, FSM state type and vector helper for the NRISC interrupt controller.
package nrisc_interrupt_ctrl_pkg;

  localparam int unsigned DEF_N_IRQ     = 8;
  localparam logic [7:0]  IRQ_VEC_BASE  = 8'h02;
  localparam int unsigned IRQ_VEC_SHIFT = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ARM    = 2'd1,
    IRQ_ACTIVE = 2'd2
  } irq_state_t;

  // Vector address wraps modulo 256.
  function automatic logic [7:0] irq_vector(input logic [7:0] base,
                                            input int unsigned shift,
                                            input logic [2:0] idx);
    return base + (8'(idx) << shift);
  endfunction

endpackage

// File: rtl/nrisc_irq_prio_enc.sv
// Combinational priority encoder: lowest set request index wins.
module nrisc_irq_prio_enc
  import nrisc_interrupt_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = DEF_N_IRQ
) (
  input  logic [N_IRQ-1:0] req,
  output logic [2:0]       idx,
  output logic             valid
);

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    idx = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if ((req & ((N_IRQ)'(1) << (i - 1))) != '0) idx = 3'(i - 1);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/nrisc_interrupt_ctrl.sv
// NRISC interrupt controller: edge-latched pending, mask, priority, one vectored request at a time.
// Optional input synchroniser enabled by defining NRISC_IRQ_SYNC_EN.
module nrisc_interrupt_ctrl
  import nrisc_interrupt_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ     = DEF_N_IRQ,
  parameter logic [7:0]  VEC_BASE  = IRQ_VEC_BASE,
  parameter int unsigned VEC_SHIFT = IRQ_VEC_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] IRQ_in,
  input  logic             CORE_INT_en,
  input  logic             CORE_MASK_we,
  input  logic [N_IRQ-1:0] CORE_MASK_data,
  input  logic             CORE_RETI,
  input  logic [1:0]       CORE_PC_ctrl,
  input  logic [1:0]       CORE_STACK_ctrl,
  output logic             INTERRUPT_flag,
  output logic [7:0]       INTERRUPT_ch,
  output logic             INT_active,
  output logic [N_IRQ-1:0] INT_pending
);

  irq_state_t       state, state_nx;
  logic [N_IRQ-1:0] irq_s, prev, rise, pending, mask, cand, clr;
  logic [2:0]       idx;
  logic             valid, take, quiet;

`ifdef NRISC_IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= IRQ_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = IRQ_in;
`endif

  assign rise  = irq_s & ~prev;
  assign cand  = pending & mask;
  assign quiet = (CORE_PC_ctrl == 2'b00) && (CORE_STACK_ctrl == 2'b00);
  assign take  = (state == IRQ_IDLE) && CORE_INT_en && valid;
  assign clr   = take ? ((N_IRQ)'(1) << idx) : '0;

  nrisc_irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req   (cand),
    .idx   (idx),
    .valid (valid)
  );

  // A new edge on the line being selected wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev         <= '0;
      pending      <= '0;
      mask         <= '0;
      INTERRUPT_ch <= '0;
    end else begin
      prev    <= irq_s;
      pending <= (pending & ~clr) | rise;
      if (CORE_MASK_we) mask <= CORE_MASK_data;
      if (take) INTERRUPT_ch <= irq_vector(VEC_BASE, VEC_SHIFT, idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IRQ_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IRQ_IDLE:   if (take)      state_nx = IRQ_ARM;
      IRQ_ARM:    if (quiet)     state_nx = IRQ_ACTIVE;
      IRQ_ACTIVE: if (CORE_RETI) state_nx = IRQ_IDLE;
      default:                   state_nx = IRQ_IDLE;
    endcase
  end

  always_comb begin
    INTERRUPT_flag = (state == IRQ_ARM) && quiet;
    INT_active     = (state == IRQ_ACTIVE);
  end

  assign INT_pending = pending;

endmodule

// File: tb/tb_nrisc_interrupt_ctrl.sv
// Directed self-checking bench for nrisc_interrupt_ctrl (default build, no input synchroniser).
module tb_nrisc_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] IRQ_in;
  logic       CORE_INT_en;
  logic       CORE_MASK_we;
  logic [7:0] CORE_MASK_data;
  logic       CORE_RETI;
  logic [1:0] CORE_PC_ctrl;
  logic [1:0] CORE_STACK_ctrl;
  logic       INTERRUPT_flag;
  logic [7:0] INTERRUPT_ch;
  logic       INT_active;
  logic [7:0] INT_pending;

  int unsigned tests = 0;
  int unsigned fails = 0;

  nrisc_interrupt_ctrl #(.N_IRQ(8), .VEC_BASE(8'h02), .VEC_SHIFT(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .IRQ_in          (IRQ_in),
    .CORE_INT_en     (CORE_INT_en),
    .CORE_MASK_we    (CORE_MASK_we),
    .CORE_MASK_data  (CORE_MASK_data),
    .CORE_RETI       (CORE_RETI),
    .CORE_PC_ctrl    (CORE_PC_ctrl),
    .CORE_STACK_ctrl (CORE_STACK_ctrl),
    .INTERRUPT_flag  (INTERRUPT_flag),
    .INTERRUPT_ch    (INTERRUPT_ch),
    .INT_active      (INT_active),
    .INT_pending     (INT_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mask_write(input logic [7:0] m);
    CORE_MASK_we   = 1'b1;
    CORE_MASK_data = m;
    tick();
    CORE_MASK_we   = 1'b0;
  endtask

  task automatic reti();
    CORE_RETI = 1'b1;
    tick();
    CORE_RETI = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; IRQ_in = '0; CORE_INT_en = 1'b0; CORE_MASK_we = 1'b0;
    CORE_MASK_data = '0; CORE_RETI = 1'b0; CORE_PC_ctrl = '0; CORE_STACK_ctrl = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_flag",    32'(INTERRUPT_flag), 32'h0);
    check("rst_ch",      32'(INTERRUPT_ch),   32'h00);
    check("rst_active",  32'(INT_active),     32'h0);
    check("rst_pending", 32'(INT_pending),    32'h00);

    // Single source: line 3 -> vector 0x0E.
    mask_write(8'hFF);
    CORE_INT_en = 1'b1;
    IRQ_in = 8'h08; tick(); IRQ_in = '0;
    check("t1_pending", 32'(INT_pending),    32'h08);
    check("t1_noflag",  32'(INTERRUPT_flag), 32'h0);
    tick();
    check("t1_flag",    32'(INTERRUPT_flag), 32'h1);
    check("t1_ch",      32'(INTERRUPT_ch),   32'h0E);
    check("t1_clr",     32'(INT_pending),    32'h00);
    tick();
    check("t1_flag_1cy", 32'(INTERRUPT_flag), 32'h0);
    check("t1_active",   32'(INT_active),     32'h1);
    tick(); tick();
    check("t1_hold",     32'(INT_active),     32'h1);
    check("t1_ch_hold",  32'(INTERRUPT_ch),   32'h0E);
    reti();
    check("t1_reti",     32'(INT_active),     32'h0);

    // Simultaneous rise on lines 5 and 1: line 1 first.
    IRQ_in = 8'h22; tick(); IRQ_in = '0;
    check("t2_pending", 32'(INT_pending),    32'h22);
    tick();
    check("t2_flag_a",  32'(INTERRUPT_flag), 32'h1);
    check("t2_ch_a",    32'(INTERRUPT_ch),   32'h06);
    check("t2_pend_a",  32'(INT_pending),    32'h20);
    tick();
    check("t2_nonest",  32'(INTERRUPT_flag), 32'h0);
    reti();
    check("t2_idle",    32'(INTERRUPT_flag), 32'h0);
    tick();
    check("t2_flag_b",  32'(INTERRUPT_flag), 32'h1);
    check("t2_ch_b",    32'(INTERRUPT_ch),   32'h16);
    check("t2_pend_b",  32'(INT_pending),    32'h00);
    tick();
    reti();

    // Stalled ARM: line 4 -> 0x12; PC busy 3 cycles, stray RETI ignored in ARM.
    IRQ_in = 8'h10; tick(); IRQ_in = '0;
    CORE_PC_ctrl = 2'b01;
    tick();
    check("t3_ch",     32'(INTERRUPT_ch),   32'h12);
    check("t3_stall0", 32'(INTERRUPT_flag), 32'h0);
    CORE_RETI = 1'b1;
    tick();
    CORE_RETI = 1'b0;
    check("t3_stall1", 32'(INTERRUPT_flag), 32'h0);
    tick();
    check("t3_stall2", 32'(INTERRUPT_flag), 32'h0);
    CORE_PC_ctrl = 2'b00; CORE_STACK_ctrl = 2'b10;
    #1;
    check("t3_stack_busy", 32'(INTERRUPT_flag), 32'h0);
    tick();
    check("t3_stall3", 32'(INT_active), 32'h0);
    CORE_STACK_ctrl = 2'b00;
    #1;
    check("t3_flag",   32'(INTERRUPT_flag), 32'h1);
    tick();
    check("t3_active", 32'(INT_active),     32'h1);
    reti();

    // Masked source stays pending until the mask enables it.
    mask_write(8'h00);
    IRQ_in = 8'h04; tick(); IRQ_in = '0;
    check("t4_pending", 32'(INT_pending), 32'h04);
    tick(); tick();
    check("t4_noflag",  32'(INTERRUPT_flag), 32'h0);
    check("t4_idle",    32'(INT_active),     32'h0);
    check("t4_keep",    32'(INT_pending),    32'h04);
    mask_write(8'h04);
    check("t4_mask_lat", 32'(INTERRUPT_flag), 32'h0);
    tick();
    check("t4_flag",    32'(INTERRUPT_flag), 32'h1);
    check("t4_ch",      32'(INTERRUPT_ch),   32'h0A);
    tick();
    reti();
    mask_write(8'hFF);

    // Stray RETI in IDLE, then line 7 -> 0x1E; line 0 arrives while active.
    reti();
    check("t5_stray_act",  32'(INT_active),     32'h0);
    check("t5_stray_flag", 32'(INTERRUPT_flag), 32'h0);
    IRQ_in = 8'h80; tick(); IRQ_in = '0;
    tick();
    check("t5_ch7",     32'(INTERRUPT_ch), 32'h1E);
    tick();
    IRQ_in = 8'h01; tick(); IRQ_in = '0;
    check("t5_pend0",   32'(INT_pending),    32'h01);
    tick(); tick();
    check("t5_noflag",  32'(INTERRUPT_flag), 32'h0);
    check("t5_active",  32'(INT_active),     32'h1);
    reti();
    check("t5_idle",    32'(INTERRUPT_flag), 32'h0);
    tick();
    check("t5_flag",    32'(INTERRUPT_flag), 32'h1);
    check("t5_ch0",     32'(INTERRUPT_ch),   32'h02);
    tick();
    reti();

    // Asynchronous reset while in ARM with another source pending.
    IRQ_in = 8'h42; tick(); IRQ_in = '0;
    CORE_PC_ctrl = 2'b11;
    tick();
    CORE_PC_ctrl = 2'b00;
    #1;
    check("t6_flag_pre", 32'(INTERRUPT_flag), 32'h1);
    check("t6_pend_pre", 32'(INT_pending),    32'h40);
    rst = 1'b1;
    #1;
    check("t6_flag",    32'(INTERRUPT_flag), 32'h0);
    check("t6_active",  32'(INT_active),     32'h0);
    check("t6_pending", 32'(INT_pending),    32'h00);
    check("t6_ch",      32'(INTERRUPT_ch),   32'h00);
    tick();
    rst = 1'b0;
    IRQ_in = 8'h01; tick(); IRQ_in = '0;
    tick(); tick();
    check("t6_mask_rst", 32'(INTERRUPT_flag), 32'h0);
    check("t6_pend_new", 32'(INT_pending),    32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
